// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use bubbles, branch redirects and
// data-memory wait states for the 5-stage core, plus stall statistics.
module hazard_controller #(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [4:0]       reg_addr1_i,
  input  logic [4:0]       reg_addr2_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic [4:0]       id_ex_reg_wr_addr_i,
  input  logic             id_ex_reg_wr_sig_i,
  input  logic [1:0]       id_ex_data_dest_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             pipe_freeze_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int unsigned BUB_W    = 4;
  localparam int unsigned WAIT_W   = 16;
  localparam logic [1:0]  DEST_MEM = 2'd1;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BUB_W-1:0]   bub_q, bub_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic load_use_c;
  logic mem_wait_c;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_flush_c, freeze_c;

  // Hazard detection: load in EX whose rd feeds a source operand in ID
  always_comb begin
    load_use_c = id_ex_reg_wr_sig_i && (id_ex_data_dest_i == DEST_MEM) &&
                 (id_ex_reg_wr_addr_i != 5'd0) &&
                 ((rs1_used_i && (reg_addr1_i == id_ex_reg_wr_addr_i)) ||
                  (rs2_used_i && (reg_addr2_i == id_ex_reg_wr_addr_i)));
    mem_wait_c = dmem_req_i && !dmem_ready_i;
  end

  // Next-state and control decode; priority mem wait > redirect > load-use
  always_comb begin
    state_d       = state_q;
    bub_d         = bub_q;
    wait_d        = wait_q;
    timeout_d     = timeout_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    freeze_c      = 1'b0;

    if (mem_wait_c) begin
      // Any state: freeze everything, bubble count held, count wait cycles
      freeze_c      = 1'b1;
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      state_d       = ST_MEM_WAIT;
      wait_d        = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
      unique case (state_q)
        ST_REDIRECT: begin
          if (branch_taken_i) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            bub_d         = BUB_W'(REDIRECT_BUBBLES);
          end else begin
            if_id_flush_c = 1'b1;
            bub_d         = (bub_q == '0) ? bub_q : bub_q - BUB_W'(1);
            if (bub_q <= BUB_W'(1)) state_d = ST_RUN;
          end
        end
        default: begin
          // RUN, and the release cycle of MEM_WAIT (remaining bubbles dropped)
          state_d = ST_RUN;
          bub_d   = '0;
          if (branch_taken_i) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            if (REDIRECT_BUBBLES != 0) begin
              state_d = ST_REDIRECT;
              bub_d   = BUB_W'(REDIRECT_BUBBLES);
            end
          end else if (load_use_c) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
      endcase
    end

    if (mem_wait_c && (MEM_TIMEOUT != 0) && (wait_d == WAIT_W'(MEM_TIMEOUT)))
      timeout_d = 1'b1;
  end

  // Controls are forced low while reset is asserted
  assign pc_stall_o    = rst_n_i & pc_stall_c;
  assign if_id_stall_o = rst_n_i & if_id_stall_c;
  assign if_id_flush_o = rst_n_i & if_id_flush_c;
  assign id_ex_flush_o = rst_n_i & id_ex_flush_c;
  assign pipe_freeze_o = rst_n_i & freeze_c;
  assign mem_timeout_o = timeout_q;
  assign stall_count_o = cnt_q;

  // Saturating count of PC-stall cycles
  always_comb begin
    cnt_d = cnt_q;
    if (pc_stall_o && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_RUN;
      bub_q     <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bub_q     <= bub_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (REDIRECT_BUBBLES=2, MEM_TIMEOUT=3, CNT_W=4).
module tb_hazard_controller;

  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] D_ALU = 2'd0;
  localparam logic [1:0] D_MEM = 2'd1;
  localparam logic [1:0] D_PC  = 2'd2;
  // expected control code bits: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, freeze}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_LU   = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_RD   = 5'b00100;
  localparam logic [4:0] C_FRZ  = 5'b11001;

  typedef struct {
    string            name;
    logic             rst_n;
    logic [4:0]       a1;
    logic             u1;
    logic [4:0]       a2;
    logic             u2;
    logic [4:0]       rd;
    logic             wr;
    logic [1:0]       dest;
    logic             br;
    logic             req;
    logic             rdy;
    logic [4:0]       ctl;
    logic             to;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] a1 = '0, a2 = '0, rd = '0;
  logic u1 = 1'b0, u2 = 1'b0, wr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic [1:0] dest = '0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_flush, freeze, timeout;
  logic [CNT_W-1:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  hazard_controller #(
    .REDIRECT_BUBBLES(2),
    .MEM_TIMEOUT(3),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .reg_addr1_i(a1),
    .reg_addr2_i(a2),
    .rs1_used_i(u1),
    .rs2_used_i(u2),
    .id_ex_reg_wr_addr_i(rd),
    .id_ex_reg_wr_sig_i(wr),
    .id_ex_data_dest_i(dest),
    .branch_taken_i(br),
    .dmem_req_i(req),
    .dmem_ready_i(rdy),
    .pc_stall_o(pc_stall),
    .if_id_stall_o(if_id_stall),
    .if_id_flush_o(if_id_flush),
    .id_ex_flush_o(id_ex_flush),
    .pipe_freeze_o(freeze),
    .mem_timeout_o(timeout),
    .stall_count_o(cnt)
  );

  function automatic vec_t mk(string name, logic r, logic [4:0] x1, logic xu1,
                              logic [4:0] x2, logic xu2, logic [4:0] xrd, logic xwr,
                              logic [1:0] xd, logic xbr, logic xreq, logic xrdy,
                              logic [4:0] c, logic t, int n);
    vec_t v;
    v.name = name; v.rst_n = r; v.a1 = x1; v.u1 = xu1; v.a2 = x2; v.u2 = xu2;
    v.rd = xrd; v.wr = xwr; v.dest = xd; v.br = xbr; v.req = xreq; v.rdy = xrdy;
    v.ctl = c; v.to = t; v.cnt = CNT_W'(n);
    return v;
  endfunction

  function automatic vec_t idle(string name, logic [4:0] c, logic t, int n);
    return mk(name, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, 1'b0, 1'b0, 1'b0, c, t, n);
  endfunction

  function automatic vec_t memv(string name, logic r, logic xrdy, logic xbr, logic [4:0] c, logic t, int n);
    return mk(name, r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, xbr, 1'b1, xrdy, c, t, n);
  endfunction

  // Drive one cycle of stimulus just after the rising edge and queue its expectation
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst_n = v.rst_n; a1 = v.a1; u1 = v.u1; a2 = v.a2; u2 = v.u2;
    rd = v.rd; wr = v.wr; dest = v.dest; br = v.br; req = v.req; rdy = v.rdy;
    sb.push_back(v);
  endtask

  // Scoreboard: compare the cycle's outputs on the falling edge
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      vec_t e;
      logic [4:0] act;
      e = sb.pop_front();
      act = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, freeze};
      n_checks++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      n_checks++;
      if (timeout === e.to) n_pass++;
      else $display("FAIL %s timeout: got %b expected %b", e.name, timeout, e.to);
      n_checks++;
      if (cnt === e.cnt) n_pass++;
      else $display("FAIL %s count: got %0d expected %0d", e.name, cnt, e.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and load-use detection
    tbl.push_back(mk("rst_lu",   1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 0));
    tbl.push_back(mk("rst_br",   1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, 1'b1, 1'b1, 1'b0, C_NONE, 1'b0, 0));
    tbl.push_back(mk("lu_rs2",   1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 0));
    tbl.push_back(mk("lu_bub",   1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, D_MEM, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(mk("ld_x0",    1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(mk("rs2_unus", 1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(mk("alu_dest", 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_ALU, 1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(mk("pc_dest",  1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_PC,  1'b0, 1'b0, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(mk("lu_rs1",   1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_LU,   1'b0, 1));
    tbl.push_back(idle("lu1_bub", C_NONE, 1'b0, 2));
    // redirects
    tbl.push_back(mk("br",       1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 2));
    tbl.push_back(idle("br_b1", C_RD, 1'b0, 2));
    tbl.push_back(idle("br_b2", C_RD, 1'b0, 2));
    tbl.push_back(idle("br_end", C_NONE, 1'b0, 2));
    tbl.push_back(mk("br_lu",    1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 2));
    tbl.push_back(mk("br_rel",   1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, 1'b1, 1'b0, 1'b0, C_BR,   1'b0, 2));
    tbl.push_back(idle("rel_b1", C_RD, 1'b0, 2));
    tbl.push_back(idle("rel_b2", C_RD, 1'b0, 2));
    tbl.push_back(idle("rel_end", C_NONE, 1'b0, 2));
    // memory wait of 4 cycles, load-use bubble in the release cycle
    tbl.push_back(memv("mw1", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 2));
    tbl.push_back(memv("mw2", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 3));
    tbl.push_back(memv("mw3", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 4));
    tbl.push_back(memv("mw4", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b1, 5));
    tbl.push_back(mk("mw_rel_lu", 1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b0, 1'b1, 1'b1, C_LU, 1'b1, 6));
    tbl.push_back(idle("mw_bub", C_NONE, 1'b1, 7));
    tbl.push_back(memv("rst_a", 1'b0, 1'b0, 1'b0, C_NONE, 1'b1, 7));
    tbl.push_back(idle("post_rst_a", C_NONE, 1'b0, 0));
    // memory wait inside a redirect drops remaining bubbles
    tbl.push_back(mk("br2",      1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, D_ALU, 1'b1, 1'b0, 1'b0, C_BR, 1'b0, 0));
    tbl.push_back(memv("rd_mw",  1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 0));
    tbl.push_back(memv("rd_rel", 1'b1, 1'b1, 1'b0, C_NONE, 1'b0, 1));
    tbl.push_back(idle("rd_drop", C_NONE, 1'b0, 1));
    // branch ignored during wait, fires in release cycle
    tbl.push_back(memv("mwb1",   1'b1, 1'b0, 1'b1, C_FRZ, 1'b0, 1));
    tbl.push_back(mk("mwb2_lu",  1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b1, 1'b1, 1'b0, C_FRZ, 1'b0, 2));
    tbl.push_back(memv("mwb_rel", 1'b1, 1'b1, 1'b1, C_BR, 1'b0, 3));
    tbl.push_back(idle("mwb_b1", C_RD, 1'b0, 3));
    tbl.push_back(idle("mwb_b2", C_RD, 1'b0, 3));
    tbl.push_back(idle("mwb_end", C_NONE, 1'b0, 3));
    // timeout, then reset in the middle of the wait
    tbl.push_back(memv("to1", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 3));
    tbl.push_back(memv("to2", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 4));
    tbl.push_back(memv("to3", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b0, 5));
    tbl.push_back(memv("to4", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b1, 6));
    tbl.push_back(memv("to5", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b1, 7));
    tbl.push_back(memv("to6", 1'b1, 1'b0, 1'b0, C_FRZ, 1'b1, 8));
    tbl.push_back(memv("to_rst", 1'b0, 1'b0, 1'b0, C_NONE, 1'b1, 9));
    tbl.push_back(idle("to_post", C_NONE, 1'b0, 0));
    tbl.push_back(mk("post_lu",  1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, D_MEM, 1'b0, 1'b0, 1'b0, C_LU, 1'b0, 0));
    tbl.push_back(idle("post_bub", C_NONE, 1'b0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // long wait saturates the 4-bit stall counter
    for (int i = 0; i < 20; i++)
      apply(memv("sat", 1'b1, 1'b0, 1'b0, C_FRZ, (i >= 3) ? 1'b1 : 1'b0, (i + 1 > 15) ? 15 : i + 1));
    apply(idle("sat_rel", C_NONE, 1'b1, 15));
    apply(idle("sat_hold", C_NONE, 1'b1, 15));

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
